// File: rtl/pic_pkg.sv
// pic_pkg: shared constants for the 8259 command register file.
//  - FSM state encodings for the initialization sequence
//  - cmd_nr encodings for ICW1..4 and OCW1..3
//  - bit positions inside ICW1, ICW4 and OCW3
package pic_pkg;

  localparam logic [2:0] StUninit   = 3'd0;
  localparam logic [2:0] StWaitIcw2 = 3'd1;
  localparam logic [2:0] StWaitIcw3 = 3'd2;
  localparam logic [2:0] StWaitIcw4 = 3'd3;
  localparam logic [2:0] StReady    = 3'd4;

  localparam logic [1:0] NrIcw1 = 2'd0;
  localparam logic [1:0] NrIcw2 = 2'd1;
  localparam logic [1:0] NrIcw3 = 2'd2;
  localparam logic [1:0] NrIcw4 = 2'd3;

  localparam logic [1:0] NrOcw1 = 2'd0;
  localparam logic [1:0] NrOcw2 = 2'd1;
  localparam logic [1:0] NrOcw3 = 2'd2;

  localparam int unsigned Icw1Ic4  = 0;
  localparam int unsigned Icw1Sngl = 1;
  localparam int unsigned Icw1Ltim = 3;

  localparam int unsigned Icw4Upm  = 0;
  localparam int unsigned Icw4Aeoi = 1;
  localparam int unsigned Icw4Buf  = 2;  // two bits, D3..D2
  localparam int unsigned Icw4Sfnm = 4;

  localparam int unsigned Ocw3Ris  = 0;
  localparam int unsigned Ocw3Rr   = 1;
  localparam int unsigned Ocw3P    = 2;
  localparam int unsigned Ocw3Smm  = 5;
  localparam int unsigned Ocw3Esmm = 6;

endpackage

// File: rtl/pic_cmd_regfile_if.sv
// pic_cmd_regfile_if: CPU-side bus between the read/write decode stage and the
// command register file.
//  wr_n, cs_n, a0  raw CPU strobes/address (asynchronous to clk)
//  cmd_type/cmd_nr decoder classification of the current write
//  bus_data        internal data bus
//  rd_data         registered readback from the register file
interface pic_cmd_regfile_if;
  logic       wr_n;
  logic       cs_n;
  logic       a0;
  logic       cmd_type;
  logic [1:0] cmd_nr;
  logic [7:0] bus_data;
  logic [7:0] rd_data;

  modport master (
    output wr_n, cs_n, a0, cmd_type, cmd_nr, bus_data,
    input  rd_data
  );

  modport slave (
    input  wr_n, cs_n, a0, cmd_type, cmd_nr, bus_data,
    output rd_data
  );
endinterface

// File: rtl/pic_sync_edge.sv
// pic_sync_edge: Stages-flop synchronizer with rising-edge detect.
//  clk, rst_n  clock, asynchronous active-low reset
//  d_i         asynchronous input
//  q_o         synchronized level
//  rise_o      one-cycle 0->1 indication on the synchronized level
// The chain and the edge history reset to ResetVal, so leaving reset never
// looks like an edge when ResetVal matches the idle level.
module pic_sync_edge #(
  parameter int unsigned Stages   = 2,
  parameter logic        ResetVal = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o,
  output logic rise_o
);

  logic [Stages-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {Stages{ResetVal}};
      prev_q <= ResetVal;
    end else begin
      sync_q <= {sync_q[Stages-2:0], d_i};
      prev_q <= sync_q[Stages-1];
    end
  end

  assign q_o    = sync_q[Stages-1];
  assign rise_o = sync_q[Stages-1] & ~prev_q;

endmodule

// File: rtl/pic_cmd_regfile.sv
// pic_cmd_regfile: 8259 command register file.
//  clk, rst_n      clock, asynchronous active-low reset
//  bus             CPU-side bus (strobes, decode class, data, rd_data)
//  irr_in, isr_in  request / in-service registers for readback
//  init_done .. seq_err  mode fields, IMR and command pulses to priority logic
// Writes are captured while the synced strobes are low and committed on the
// synced wr_n rising edge; all outputs are registered.
module pic_cmd_regfile
  import pic_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  IMR_RESET   = 8'h00
) (
  input  logic                     clk,
  input  logic                     rst_n,
  pic_cmd_regfile_if.slave         bus,
  input  logic [7:0]               irr_in,
  input  logic [7:0]               isr_in,
  output logic                     init_done,
  output logic                     icw1_pulse,
  output logic                     ltim,
  output logic                     sngl,
  output logic [4:0]               vector_base,
  output logic [7:0]               cascade_cfg,
  output logic                     upm,
  output logic                     aeoi,
  output logic [1:0]               buf_ms,
  output logic                     sfnm,
  output logic [7:0]               imr,
  output logic                     eoi_valid,
  output logic [2:0]               eoi_cmd,
  output logic [2:0]               eoi_level,
  output logic                     smm,
  output logic                     poll_pulse,
  output logic                     seq_err
);

  logic wr_sync, wr_rise;
  logic [SYNC_STAGES-1:0] cs_sync_q, a0_sync_q;
  logic cs_sync, a0_sync;

  pic_sync_edge #(
    .Stages  (SYNC_STAGES),
    .ResetVal(1'b1)
  ) u_wr_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (bus.wr_n),
    .q_o   (wr_sync),
    .rise_o(wr_rise)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_sync_q <= '1;
      a0_sync_q <= '0;
    end else begin
      cs_sync_q <= {cs_sync_q[SYNC_STAGES-2:0], bus.cs_n};
      a0_sync_q <= {a0_sync_q[SYNC_STAGES-2:0], bus.a0};
    end
  end

  assign cs_sync = cs_sync_q[SYNC_STAGES-1];
  assign a0_sync = a0_sync_q[SYNC_STAGES-1];

  logic [2:0] state_q, state_d;
  logic [7:0] data_q, data_d;
  logic       type_q, type_d;
  logic [1:0] nr_q, nr_d;
  logic       cs_prev_q;
  logic       ic4_q, ic4_d;
  logic       rd_sel_q, rd_sel_d;
  logic       init_done_q, init_done_d, ltim_q, ltim_d, sngl_q, sngl_d;
  logic [4:0] vector_base_q, vector_base_d;
  logic [7:0] cascade_q, cascade_d, imr_q, imr_d, rd_data_q, rd_data_d;
  logic       upm_q, upm_d, aeoi_q, aeoi_d, sfnm_q, sfnm_d, smm_q, smm_d;
  logic [1:0] buf_ms_q, buf_ms_d;
  logic [2:0] eoi_cmd_q, eoi_cmd_d, eoi_level_q, eoi_level_d;
  logic       icw1_p_q, icw1_p_d, eoi_p_q, eoi_p_d, poll_p_q, poll_p_d, err_p_q, err_p_d;
  logic       commit, enter_ready;

  assign commit = wr_rise & ~cs_prev_q;

  always_comb begin
    state_d       = state_q;
    data_d        = data_q;
    type_d        = type_q;
    nr_d          = nr_q;
    ic4_d         = ic4_q;
    rd_sel_d      = rd_sel_q;
    init_done_d   = init_done_q;
    ltim_d        = ltim_q;
    sngl_d        = sngl_q;
    vector_base_d = vector_base_q;
    cascade_d     = cascade_q;
    upm_d         = upm_q;
    aeoi_d        = aeoi_q;
    buf_ms_d      = buf_ms_q;
    sfnm_d        = sfnm_q;
    imr_d         = imr_q;
    eoi_cmd_d     = eoi_cmd_q;
    eoi_level_d   = eoi_level_q;
    smm_d         = smm_q;
    icw1_p_d      = 1'b0;
    eoi_p_d       = 1'b0;
    poll_p_d      = 1'b0;
    err_p_d       = 1'b0;
    enter_ready   = 1'b0;

    if (!wr_sync && !cs_sync) begin
      data_d = bus.bus_data;
      type_d = bus.cmd_type;
      nr_d   = bus.cmd_nr;
    end

    if (commit) begin
      if (type_q) begin
        if (nr_q == NrIcw1) begin
          ltim_d      = data_q[Icw1Ltim];
          sngl_d      = data_q[Icw1Sngl];
          ic4_d       = data_q[Icw1Ic4];
          imr_d       = IMR_RESET;
          smm_d       = 1'b0;
          rd_sel_d    = 1'b0;
          upm_d       = 1'b0;
          aeoi_d      = 1'b0;
          buf_ms_d    = 2'b00;
          sfnm_d      = 1'b0;
          init_done_d = 1'b0;
          icw1_p_d    = 1'b1;
          state_d     = StWaitIcw2;
        end else if (state_q == StWaitIcw2 && nr_q == NrIcw2) begin
          vector_base_d = data_q[7:3];
          if (!sngl_q)    state_d = StWaitIcw3;
          else if (ic4_q) state_d = StWaitIcw4;
          else            enter_ready = 1'b1;
        end else if (state_q == StWaitIcw3 && nr_q == NrIcw3) begin
          cascade_d = data_q;
          if (ic4_q) state_d = StWaitIcw4;
          else       enter_ready = 1'b1;
        end else if (state_q == StWaitIcw4 && nr_q == NrIcw4) begin
          upm_d       = data_q[Icw4Upm];
          aeoi_d      = data_q[Icw4Aeoi];
          buf_ms_d    = data_q[Icw4Buf+1 -: 2];
          sfnm_d      = data_q[Icw4Sfnm];
          enter_ready = 1'b1;
        end else begin
          err_p_d = 1'b1;
        end
      end else if (state_q != StReady) begin
        err_p_d = 1'b1;
      end else begin
        case (nr_q)
          NrOcw1: imr_d = data_q;
          NrOcw2: begin
            eoi_cmd_d   = data_q[7:5];
            eoi_level_d = data_q[2:0];
            eoi_p_d     = 1'b1;
          end
          NrOcw3: begin
            if (data_q[Ocw3Esmm]) smm_d    = data_q[Ocw3Smm];
            if (data_q[Ocw3Rr])   rd_sel_d = data_q[Ocw3Ris];
            poll_p_d = data_q[Ocw3P];
          end
          default: err_p_d = 1'b1;
        endcase
      end
    end

    if (enter_ready) begin
      state_d     = StReady;
      init_done_d = 1'b1;
    end

    rd_data_d = a0_sync ? imr_q : (rd_sel_q ? isr_in : irr_in);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StUninit;
      data_q        <= '0;
      type_q        <= 1'b0;
      nr_q          <= '0;
      cs_prev_q     <= 1'b1;
      ic4_q         <= 1'b0;
      rd_sel_q      <= 1'b0;
      init_done_q   <= 1'b0;
      ltim_q        <= 1'b0;
      sngl_q        <= 1'b0;
      vector_base_q <= '0;
      cascade_q     <= '0;
      upm_q         <= 1'b0;
      aeoi_q        <= 1'b0;
      buf_ms_q      <= '0;
      sfnm_q        <= 1'b0;
      imr_q         <= IMR_RESET;
      eoi_cmd_q     <= '0;
      eoi_level_q   <= '0;
      smm_q         <= 1'b0;
      rd_data_q     <= '0;
      icw1_p_q      <= 1'b0;
      eoi_p_q       <= 1'b0;
      poll_p_q      <= 1'b0;
      err_p_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      data_q        <= data_d;
      type_q        <= type_d;
      nr_q          <= nr_d;
      cs_prev_q     <= cs_sync;
      ic4_q         <= ic4_d;
      rd_sel_q      <= rd_sel_d;
      init_done_q   <= init_done_d;
      ltim_q        <= ltim_d;
      sngl_q        <= sngl_d;
      vector_base_q <= vector_base_d;
      cascade_q     <= cascade_d;
      upm_q         <= upm_d;
      aeoi_q        <= aeoi_d;
      buf_ms_q      <= buf_ms_d;
      sfnm_q        <= sfnm_d;
      imr_q         <= imr_d;
      eoi_cmd_q     <= eoi_cmd_d;
      eoi_level_q   <= eoi_level_d;
      smm_q         <= smm_d;
      rd_data_q     <= rd_data_d;
      icw1_p_q      <= icw1_p_d;
      eoi_p_q       <= eoi_p_d;
      poll_p_q      <= poll_p_d;
      err_p_q       <= err_p_d;
    end
  end

  assign bus.rd_data  = rd_data_q;
  assign init_done    = init_done_q;
  assign icw1_pulse   = icw1_p_q;
  assign ltim         = ltim_q;
  assign sngl         = sngl_q;
  assign vector_base  = vector_base_q;
  assign cascade_cfg  = cascade_q;
  assign upm          = upm_q;
  assign aeoi         = aeoi_q;
  assign buf_ms       = buf_ms_q;
  assign sfnm         = sfnm_q;
  assign imr          = imr_q;
  assign eoi_valid    = eoi_p_q;
  assign eoi_cmd      = eoi_cmd_q;
  assign eoi_level    = eoi_level_q;
  assign smm          = smm_q;
  assign poll_pulse   = poll_p_q;
  assign seq_err      = err_p_q;

endmodule

// File: tb/tb_pic_cmd_regfile.sv
// Directed bench for pic_cmd_regfile: init sequences, OCW decode, readback
// timing, sequence errors and reset in the middle of a write.
module tb_pic_cmd_regfile;
  import pic_pkg::*;

  localparam int unsigned N = 2;
  localparam logic [7:0] ImrRst = 8'h00;

  logic clk = 1'b0;
  logic rst_n;
  logic [7:0] irr_in, isr_in;
  logic init_done, icw1_pulse, ltim, sngl, upm, aeoi, sfnm, eoi_valid, smm;
  logic poll_pulse, seq_err;
  logic [4:0] vector_base;
  logic [7:0] cascade_cfg, imr;
  logic [1:0] buf_ms;
  logic [2:0] eoi_cmd, eoi_level;
  logic [31:0] misc;

  int n_assert = 0;
  int n_fail = 0;
  logic spurious;

  pic_cmd_regfile_if bus_if ();

  pic_cmd_regfile #(
    .SYNC_STAGES(N),
    .IMR_RESET  (ImrRst)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus_if),
    .irr_in     (irr_in),
    .isr_in     (isr_in),
    .init_done  (init_done),
    .icw1_pulse (icw1_pulse),
    .ltim       (ltim),
    .sngl       (sngl),
    .vector_base(vector_base),
    .cascade_cfg(cascade_cfg),
    .upm        (upm),
    .aeoi       (aeoi),
    .buf_ms     (buf_ms),
    .sfnm       (sfnm),
    .imr        (imr),
    .eoi_valid  (eoi_valid),
    .eoi_cmd    (eoi_cmd),
    .eoi_level  (eoi_level),
    .smm        (smm),
    .poll_pulse (poll_pulse),
    .seq_err    (seq_err)
  );

  always #5 clk = ~clk;

  // Every output except imr and rd_data; all zero in reset.
  assign misc = {init_done, icw1_pulse, ltim, sngl, vector_base, upm, aeoi, buf_ms, sfnm,
                 eoi_valid, eoi_cmd, eoi_level, smm, poll_pulse, seq_err, cascade_cfg};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Full CPU write; returns #1 after the commit edge (outputs just updated).
  task automatic write(input logic t, input logic [1:0] nr, input logic [7:0] d,
                       input logic a);
    bus_if.cmd_type = t;
    bus_if.cmd_nr   = nr;
    bus_if.bus_data = d;
    bus_if.a0       = a;
    bus_if.cs_n     = 1'b0;
    bus_if.wr_n     = 1'b0;
    step(N + 3);
    bus_if.wr_n = 1'b1;
    bus_if.cs_n = 1'b1;
    step(N + 1);
  endtask

  initial begin
    rst_n = 1'b0;
    bus_if.wr_n = 1'b1;
    bus_if.cs_n = 1'b1;
    bus_if.a0 = 1'b0;
    bus_if.cmd_type = 1'b0;
    bus_if.cmd_nr = 2'b00;
    bus_if.bus_data = 8'h00;
    irr_in = 8'hC3;
    isr_in = 8'h3C;
    step(2);
    check("reset_misc", misc, 32'h0);
    check("reset_imr", {24'h0, imr}, {24'h0, ImrRst});
    check("reset_rd", {24'h0, bus_if.rd_data}, 32'h0);
    rst_n = 1'b1;
    step(N + 2);

    // OCW before init is rejected
    write(1'b0, NrOcw1, 8'hFF, 1'b1);
    check("pre_ocw_err", {31'h0, seq_err}, 32'h1);
    check("pre_ocw_imr", {24'h0, imr}, {24'h0, ImrRst});
    step(1);
    check("pre_ocw_err_gone", {31'h0, seq_err}, 32'h0);

    // Single, IC4: ICW3 skipped
    write(1'b1, NrIcw1, 8'h13, 1'b0);
    check("t1_icw1_pulse", {31'h0, icw1_pulse}, 32'h1);
    check("t1_sngl", {31'h0, sngl}, 32'h1);
    step(1);
    check("t1_icw1_pulse_gone", {31'h0, icw1_pulse}, 32'h0);
    write(1'b1, NrIcw2, 8'h20, 1'b0);
    check("t1_vb", {27'h0, vector_base}, 32'h04);
    check("t1_init_early", {31'h0, init_done}, 32'h0);
    write(1'b1, NrIcw4, 8'h03, 1'b0);
    check("t1_init", {31'h0, init_done}, 32'h1);
    check("t1_upm_aeoi", {30'h0, upm, aeoi}, 32'h3);

    // Cascade mode with ICW3
    write(1'b1, NrIcw1, 8'h11, 1'b0);
    check("t2_sngl", {31'h0, sngl}, 32'h0);
    check("t2_upm_cleared", {31'h0, upm}, 32'h0);
    write(1'b1, NrIcw2, 8'h08, 1'b0);
    check("t2_vb", {27'h0, vector_base}, 32'h01);
    write(1'b1, NrIcw3, 8'h04, 1'b0);
    check("t2_cascade", {24'h0, cascade_cfg}, 32'h04);
    check("t2_init_before_icw4", {31'h0, init_done}, 32'h0);
    write(1'b1, NrIcw4, 8'h01, 1'b0);
    check("t2_init", {31'h0, init_done}, 32'h1);
    check("t2_upm_aeoi", {30'h0, upm, aeoi}, 32'h2);

    // OCW1 and readback latency
    write(1'b0, NrOcw1, 8'hA5, 1'b1);
    check("t3_imr", {24'h0, imr}, 32'hA5);
    check("t3_rd_early", {24'h0, bus_if.rd_data}, 32'h00);
    step(1);
    check("t3_rd", {24'h0, bus_if.rd_data}, 32'hA5);

    // OCW2 / OCW3
    write(1'b0, NrOcw2, 8'h63, 1'b1);
    check("t4_eoi_valid", {31'h0, eoi_valid}, 32'h1);
    check("t4_eoi_cmd_lvl", {26'h0, eoi_cmd, eoi_level}, {26'h0, 3'b011, 3'd3});
    step(1);
    check("t4_eoi_valid_gone", {31'h0, eoi_valid}, 32'h0);
    check("t4_eoi_held", {26'h0, eoi_cmd, eoi_level}, {26'h0, 3'b011, 3'd3});
    write(1'b0, NrOcw3, 8'h6B, 1'b0);
    check("t4_smm", {31'h0, smm}, 32'h1);
    check("t4_rd_irr", {24'h0, bus_if.rd_data}, 32'hC3);
    check("t4_no_poll", {31'h0, poll_pulse}, 32'h0);
    step(1);
    check("t4_rd_isr", {24'h0, bus_if.rd_data}, 32'h3C);
    write(1'b0, NrOcw3, 8'h0C, 1'b0);
    check("t4_poll", {31'h0, poll_pulse}, 32'h1);
    check("t4_smm_kept", {31'h0, smm}, 32'h1);
    step(1);
    check("t4_poll_gone", {31'h0, poll_pulse}, 32'h0);
    check("t4_rd_sel_kept", {24'h0, bus_if.rd_data}, 32'h3C);

    // ICW1 from READY, then out-of-order ICWs
    write(1'b1, NrIcw1, 8'h11, 1'b0);
    check("t5_icw1_pulse", {31'h0, icw1_pulse}, 32'h1);
    check("t5_imr_reset", {24'h0, imr}, {24'h0, ImrRst});
    check("t5_smm_init", {30'h0, smm, init_done}, 32'h0);
    step(1);
    check("t5_rd_sel_irr", {24'h0, bus_if.rd_data}, 32'hC3);
    write(1'b1, NrIcw3, 8'h55, 1'b0);
    check("t5_icw3_err", {31'h0, seq_err}, 32'h1);
    check("t5_cascade_kept", {24'h0, cascade_cfg}, 32'h04);
    write(1'b1, NrIcw2, 8'h28, 1'b0);
    check("t5_icw2_ok", {31'h0, seq_err}, 32'h0);
    check("t5_vb", {27'h0, vector_base}, 32'h05);
    // fresh ICW1 mid-sequence restarts at WAIT_ICW2
    write(1'b1, NrIcw1, 8'h13, 1'b0);
    check("t6_mid_icw1", {31'h0, icw1_pulse}, 32'h1);
    write(1'b1, NrIcw3, 8'h55, 1'b0);
    check("t6_icw3_err", {31'h0, seq_err}, 32'h1);
    write(1'b1, NrIcw2, 8'h20, 1'b0);
    check("t6_vb", {27'h0, vector_base}, 32'h04);
    check("t6_init_early", {31'h0, init_done}, 32'h0);
    write(1'b1, NrIcw4, 8'h02, 1'b0);
    check("t6_init", {31'h0, init_done}, 32'h1);
    check("t6_upm_aeoi", {30'h0, upm, aeoi}, 32'h1);
    check("t6_cascade", {24'h0, cascade_cfg}, 32'h04);

    // Reset in the middle of a write
    write(1'b0, NrOcw1, 8'hFF, 1'b1);
    check("t7_imr_ff", {24'h0, imr}, 32'hFF);
    bus_if.cmd_type = 1'b0;
    bus_if.cmd_nr   = NrOcw1;
    bus_if.bus_data = 8'h5A;
    bus_if.cs_n     = 1'b0;
    bus_if.wr_n     = 1'b0;
    step(N + 3);
    rst_n = 1'b0;
    #1;
    check("t7_async_misc", misc, 32'h0);
    check("t7_async_imr", {24'h0, imr}, {24'h0, ImrRst});
    step(1);
    bus_if.wr_n = 1'b1;
    bus_if.cs_n = 1'b1;
    step(2);
    rst_n = 1'b1;
    spurious = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      spurious = spurious | seq_err | icw1_pulse | eoi_valid | poll_pulse;
    end
    check("t7_no_commit", {31'h0, spurious}, 32'h0);
    check("t7_imr", {24'h0, imr}, {24'h0, ImrRst});
    check("t7_misc", misc, 32'h0);
    write(1'b1, NrIcw1, 8'h11, 1'b0);
    check("t7_icw1", {31'h0, icw1_pulse}, 32'h1);
    write(1'b1, NrIcw2, 8'h08, 1'b0);
    check("t7_icw2_accepted", {27'h0, vector_base}, 32'h01);
    check("t7_icw2_no_err", {31'h0, seq_err}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
